// File: rtl/cntr_dir_pkg.sv
// Shared types for the up/down counter direction decoder: FSM states, step kinds
// and the run-counter width.
package cntr_dir_pkg;

   localparam int STEP_W = 2;
   // Wide enough for the largest supported LOCK_CNT (15).
   localparam int RUN_W  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      LOCKED = 2'd2
   } state_t;

   typedef enum logic [STEP_W-1:0] {
      STEP_UP      = 2'd0,
      STEP_DOWN    = 2'd1,
      STEP_HOLD    = 2'd2,
      STEP_ILLEGAL = 2'd3
   } step_t;

endpackage

// File: rtl/cntr_step_class.sv
// Combinational step classifier: compares the new count with the previous one.
// CNTR_DIR_HOLD_EN defined makes an unchanged count a legal HOLD step.
module cntr_step_class
   import cntr_dir_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] count_i,
   output step_t            step_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] diff;

   // Modulo subtraction: +1 is an up step, all-ones is a down step.
   assign diff = count_i - prev_i;

   always_comb begin
      step_o = STEP_ILLEGAL;
      wrap_o = 1'b0;
      if (diff == WIDTH'(1)) begin
         step_o = STEP_UP;
         wrap_o = (prev_i == '1);
      end else if (diff == '1) begin
         step_o = STEP_DOWN;
         wrap_o = (prev_i == '0);
      end else if (diff == '0) begin
`ifdef CNTR_DIR_HOLD_EN
         step_o = STEP_HOLD;
`else
         step_o = STEP_ILLEGAL;
`endif
      end
   end

endmodule

// File: rtl/cntr_dir_decoder.sv
// Recovers the direction of an observed up/down counter stream, flags illegal
// steps and tracks lock. CNTR_DIR_HOLD_EN makes a repeated count a legal step.
module cntr_dir_decoder
   import cntr_dir_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             count_vld,
   output logic             up_down_out,
   output logic             dir_vld,
   output logic             wrap,
   output logic             step_err,
   output logic             locked,
   output logic [ERR_W-1:0] err_count,
   output state_t           dbg_state_o
);

   localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_CNT);

   state_t           state_q;
   logic [WIDTH-1:0] prev_q;
   logic [RUN_W-1:0] run_q, run_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic             up_down_q, dir_vld_q, wrap_q, step_err_q, locked_q;

   step_t            step;
   logic             step_wrap;
   logic             step_legal;
   logic             step_moved;

   cntr_step_class #(
      .WIDTH (WIDTH)
   ) u_class (
      .prev_i  (prev_q),
      .count_i (count_in),
      .step_o  (step),
      .wrap_o  (step_wrap)
   );

   always_comb begin
      step_legal = (step != STEP_ILLEGAL);
      step_moved = (step == STEP_UP) || (step == STEP_DOWN);
      run_d      = (run_q < LOCK_RUN) ? run_q + 1'b1 : run_q;
      err_d      = (err_q == '1) ? err_q : err_q + 1'b1;
   end

   // FSM, run/error counters and every output register live in one process.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         prev_q     <= '0;
         run_q      <= '0;
         err_q      <= '0;
         up_down_q  <= 1'b0;
         dir_vld_q  <= 1'b0;
         wrap_q     <= 1'b0;
         step_err_q <= 1'b0;
         locked_q   <= 1'b0;
      end else begin
         dir_vld_q  <= 1'b0;
         wrap_q     <= 1'b0;
         step_err_q <= 1'b0;
         if (count_vld) begin
            // prev follows every sample, even illegal ones, so recovery is immediate.
            prev_q <= count_in;
            case (state_q)
               IDLE: begin
                  state_q <= SEARCH;
               end
               SEARCH, LOCKED: begin
                  if (step_moved) begin
                     up_down_q <= (step == STEP_DOWN);
                     dir_vld_q <= 1'b1;
                     wrap_q    <= step_wrap;
                  end
                  if (step_legal) begin
                     run_q <= run_d;
                     if (run_d == LOCK_RUN) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     run_q      <= '0;
                     step_err_q <= 1'b1;
                     err_q      <= err_d;
                     state_q    <= SEARCH;
                     locked_q   <= 1'b0;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign up_down_out = up_down_q;
   assign dir_vld     = dir_vld_q;
   assign wrap        = wrap_q;
   assign step_err    = step_err_q;
   assign locked      = locked_q;
   assign err_count   = err_q;
   assign dbg_state_o = state_q;

endmodule
